decode_stage: RTL and testbench

- Registered instruction-decode pipeline stage for the 32-bit ARM-subset core. Sits between fetch and register-read/execute.
- Turns each fetched word into a control bundle plus operand fields, and produces an immediate already extended to the datapath width.
- Adds valid/ready flow control, flush, an optional skid buffer, rotated data-processing immediates, branch-with-link, condition passthrough and illegal-instruction flagging.

---
 rtl/decode_stage.sv | 213 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage for the 32-bit ARM-subset core.
// Turns a fetched word into a control bundle, operand fields and an immediate
// extended to DATA_W, with valid/ready handshaking, flush and an optional skid entry.
//
// Parameters:
//   DATA_W  datapath/PC width (>= 32); immediates are extended to this width
//   SKID    0: single output register, combinational in_ready
//           1: output register plus one skid entry, in_ready from skid state
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   flush                       drops held and incoming instructions
//   in_valid/in_ready           fetch handshake; in_instr, in_pc carry the word
//   out_valid/out_ready         downstream handshake for the decoded bundle
//   out_pc, out_cond            passthrough PC and condition field
//   out_funct, out_rd/rn/rm     ALU function and register indices
//   out_imm_sel, out_imm        operand-2-is-immediate and the extended immediate
//   out_reg_write ... illegal   control bits
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int SKID   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [3:0]        out_cond,
  output logic [3:0]        out_funct,
  output logic [3:0]        out_rd,
  output logic [3:0]        out_rn,
  output logic [3:0]        out_rm,
  output logic              out_imm_sel,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_reg_write,
  output logic              out_set_flags,
  output logic              out_mem_to_reg,
  output logic              out_mem_write,
  output logic              out_branch,
  output logic              out_link,
  output logic              out_illegal
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [3:0]        cond;
    logic [3:0]        funct;
    logic [3:0]        rd;
    logic [3:0]        rn;
    logic [3:0]        rm;
    logic              imm_sel;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              set_flags;
    logic              mem_to_reg;
    logic              mem_write;
    logic              branch;
    logic              link;
    logic              illegal;
  } bundle_t;

  // Rotate the 8-bit data-processing immediate right by 2*rot within 32 bits.
  function automatic logic [31:0] rot_imm_f(input logic [7:0] imm8, input logic [3:0] rot);
    logic [63:0] dbl;
    logic [4:0]  amt;
    amt = {rot, 1'b0};
    dbl = {24'h000000, imm8, 24'h000000, imm8} >> amt;
    return dbl[31:0];
  endfunction

  // Full decode of one instruction word into a bundle.
  function automatic bundle_t decode_f(input logic [31:0] instr, input logic [DATA_W-1:0] pc);
    bundle_t     b;
    logic [25:0] boff;
    b      = '0;
    b.pc   = pc;
    b.cond = instr[31:28];
    boff   = {instr[23:0], 2'b00};
    case (instr[27:26])
      2'b00: begin
        b.funct     = instr[24:21];
        b.rd        = instr[15:12];
        b.rn        = instr[19:16];
        b.set_flags = instr[20];
        // TST/TEQ/CMP/CMN (funct 10xx) only update flags
        b.reg_write = (instr[24:23] != 2'b10);
        if (instr[25]) begin
          b.imm_sel = 1'b1;
          b.imm     = DATA_W'(rot_imm_f(instr[7:0], instr[11:8]));
        end else begin
          b.rm = instr[3:0];
        end
      end
      2'b01: begin
        b.rd         = instr[15:12];
        b.rn         = instr[19:16];
        b.mem_to_reg = instr[20];
        b.reg_write  = instr[20];
        b.mem_write  = ~instr[20];
        b.funct      = instr[23] ? 4'b0100 : 4'b0010;
        // For memory ops I=0 selects the 12-bit offset
        if (!instr[25]) begin
          b.imm_sel = 1'b1;
          b.imm     = DATA_W'(instr[11:0]);
        end else begin
          b.rm = instr[3:0];
        end
      end
      2'b10: begin
        b.branch    = 1'b1;
        b.link      = instr[24];
        b.reg_write = instr[24];
        b.rd        = instr[24] ? 4'd14 : 4'd0;
        b.imm_sel   = 1'b1;
        b.imm       = DATA_W'($signed(boff));
      end
      2'b11: begin
        b.illegal = 1'b1;
      end
      default: begin
        b.illegal = 1'b1;
      end
    endcase
    // Condition 4'hF flags the word illegal and suppresses its side effects
    if (instr[31:28] == 4'hF) begin
      b.illegal   = 1'b1;
      b.reg_write = 1'b0;
      b.mem_write = 1'b0;
      b.branch    = 1'b0;
    end
    return b;
  endfunction

  bundle_t dec_s;
  bundle_t out_r;
  bundle_t skid_r;
  logic    out_valid_r;
  logic    skid_valid_r;
  logic    out_free_s;
  logic    accept_s;
  logic    in_ready_s;

  assign dec_s      = decode_f(in_instr, in_pc);
  assign out_free_s = ~out_valid_r | out_ready;
  assign accept_s   = in_valid & in_ready_s;
  assign in_ready   = in_ready_s;

  generate
    if (SKID != 0) begin : g_skid
      // in_ready follows the skid register only; rst gating keeps it low in reset
      assign in_ready_s = ~rst & ~skid_valid_r;

      // Skid entry: captures a word accepted while the output is stalled, empties on drain.
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_r       <= '0;
          skid_valid_r <= 1'b0;
        end else if (flush) begin
          skid_valid_r <= 1'b0;
        end else if (out_free_s) begin
          skid_valid_r <= 1'b0;
        end else if (accept_s) begin
          skid_r       <= dec_s;
          skid_valid_r <= 1'b1;
        end
      end
    end else begin : g_noskid
      assign in_ready_s   = ~rst & out_free_s;
      assign skid_valid_r = 1'b0;
      assign skid_r       = '0;
    end
  endgenerate

  // Output register: skid entry drains ahead of new input so order is preserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r       <= '0;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (out_free_s) begin
      out_valid_r <= skid_valid_r | accept_s;
      if (skid_valid_r) begin
        out_r <= skid_r;
      end else if (accept_s) begin
        out_r <= dec_s;
      end
    end
  end

  assign out_valid      = out_valid_r;
  assign out_pc         = out_r.pc;
  assign out_cond       = out_r.cond;
  assign out_funct      = out_r.funct;
  assign out_rd         = out_r.rd;
  assign out_rn         = out_r.rn;
  assign out_rm         = out_r.rm;
  assign out_imm_sel    = out_r.imm_sel;
  assign out_imm        = out_r.imm;
  assign out_reg_write  = out_r.reg_write;
  assign out_set_flags  = out_r.set_flags;
  assign out_mem_to_reg = out_r.mem_to_reg;
  assign out_mem_write  = out_r.mem_write;
  assign out_branch     = out_r.branch;
  assign out_link       = out_r.link;
  assign out_illegal    = out_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: instance u0 (SKID=0) covers decode, instance u1 (SKID=1) covers
// backpressure, ordering, flush and reset behaviour.
module tb_decode_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;
  logic iv0, ir0, ordy0, ov0;
  logic iv1, ir1, ordy1, ov1;
  logic [31:0] ins0, ins1, pc0, pc1;
  logic [31:0] opc0, opc1, imm0, imm1;
  logic [3:0]  cond0, cond1, fn0, fn1, rd0, rd1, rn0, rn1, rm0, rm1;
  logic isel0, isel1, rw0, rw1, sf0, sf1, m2r0, m2r1, mw0, mw1;
  logic br0, br1, lk0, lk1, il0, il1;

  int total = 0;
  int bad   = 0;

  decode_stage #(.DATA_W(32), .SKID(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv0), .in_ready(ir0), .in_instr(ins0), .in_pc(pc0),
    .out_valid(ov0), .out_ready(ordy0), .out_pc(opc0), .out_cond(cond0),
    .out_funct(fn0), .out_rd(rd0), .out_rn(rn0), .out_rm(rm0),
    .out_imm_sel(isel0), .out_imm(imm0), .out_reg_write(rw0),
    .out_set_flags(sf0), .out_mem_to_reg(m2r0), .out_mem_write(mw0),
    .out_branch(br0), .out_link(lk0), .out_illegal(il0)
  );

  decode_stage #(.DATA_W(32), .SKID(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv1), .in_ready(ir1), .in_instr(ins1), .in_pc(pc1),
    .out_valid(ov1), .out_ready(ordy1), .out_pc(opc1), .out_cond(cond1),
    .out_funct(fn1), .out_rd(rd1), .out_rn(rn1), .out_rm(rm1),
    .out_imm_sel(isel1), .out_imm(imm1), .out_reg_write(rw1),
    .out_set_flags(sf1), .out_mem_to_reg(m2r1), .out_mem_write(mw1),
    .out_branch(br1), .out_link(lk1), .out_illegal(il1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [31:0] instr, input logic [31:0] pc);
    iv0  = 1'b1;
    ins0 = instr;
    pc0  = pc;
    tick();
    iv0  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    iv0 = 1'b0; ins0 = 32'h0; pc0 = 32'h0; ordy0 = 1'b1;
    iv1 = 1'b0; ins1 = 32'h0; pc1 = 32'h0; ordy1 = 1'b0;
    #1;
    check("rst_in_ready0", ir0, 1'b0);
    check("rst_in_ready1", ir1, 1'b0);
    tick(); tick();
    check("rst_out_valid0", ov0, 1'b0);
    check("rst_out_imm0", imm0, 32'h0);
    check("rst_out_valid1", ov1, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready0", ir0, 1'b1);
    check("post_rst_in_ready1", ir1, 1'b1);

    // ADD r1, r2, #0xFF
    send0(32'hE28210FF, 32'h0);
    check("add_valid", ov0, 1'b1);
    check("add_funct", fn0, 4'h4);
    check("add_rd", rd0, 4'd1);
    check("add_rn", rn0, 4'd2);
    check("add_imm_sel", isel0, 1'b1);
    check("add_imm", imm0, 32'h000000FF);
    check("add_reg_write", rw0, 1'b1);
    check("add_set_flags", sf0, 1'b0);
    check("add_cond", cond0, 4'hE);

    // MOV r0, #0x3F ror 8 ; CMP r2, #0
    send0(32'hE3A0043F, 32'h4);
    check("mov_funct", fn0, 4'hD);
    check("mov_imm", imm0, 32'h3F000000);
    check("mov_reg_write", rw0, 1'b1);
    send0(32'hE3520000, 32'h8);
    check("cmp_funct", fn0, 4'hA);
    check("cmp_reg_write", rw0, 1'b0);
    check("cmp_set_flags", sf0, 1'b1);
    check("cmp_rn", rn0, 4'd2);

    // ADD r2, r1, r3 (register operand)
    send0(32'hE0812003, 32'hC);
    check("addr_imm_sel", isel0, 1'b0);
    check("addr_rm", rm0, 4'd3);
    check("addr_rd", rd0, 4'd2);
    check("addr_imm", imm0, 32'h0);

    // LDR r3, [r4, #8] ; STR r3, [r4, #-8]
    send0(32'hE5943008, 32'h10);
    check("ldr_m2r", m2r0, 1'b1);
    check("ldr_rw", rw0, 1'b1);
    check("ldr_mw", mw0, 1'b0);
    check("ldr_rd", rd0, 4'd3);
    check("ldr_rn", rn0, 4'd4);
    check("ldr_imm", imm0, 32'h8);
    check("ldr_funct", fn0, 4'b0100);
    send0(32'hE5043008, 32'h14);
    check("str_mw", mw0, 1'b1);
    check("str_rw", rw0, 1'b0);
    check("str_m2r", m2r0, 1'b0);
    check("str_funct", fn0, 4'b0010);

    // BL -8 at 0x100 ; NV-space branch ; op 11
    send0(32'hEBFFFFFE, 32'h100);
    check("bl_branch", br0, 1'b1);
    check("bl_link", lk0, 1'b1);
    check("bl_rd", rd0, 4'd14);
    check("bl_imm", imm0, 32'hFFFFFFF8);
    check("bl_pc", opc0, 32'h100);
    check("bl_rw", rw0, 1'b1);
    send0(32'hFA000000, 32'h104);
    check("nv_illegal", il0, 1'b1);
    check("nv_branch", br0, 1'b0);
    check("nv_rw", rw0, 1'b0);
    check("nv_cond", cond0, 4'hF);
    send0(32'hEC000000, 32'h108);
    check("op11_illegal", il0, 1'b1);
    check("op11_rw", rw0, 1'b0);
    check("op11_funct", fn0, 4'h0);
    tick();
    check("idle_valid0", ov0, 1'b0);

    // Word accepted in a flush cycle is dropped
    flush = 1'b1;
    send0(32'hE28210FF, 32'h200);
    flush = 1'b0;
    check("flush_drop0", ov0, 1'b0);
    send0(32'hE0812003, 32'h204);
    check("after_flush_valid0", ov0, 1'b1);
    check("after_flush_pc0", opc0, 32'h204);

    // SKID=1 back-to-back with out_ready high
    ordy1 = 1'b1; iv1 = 1'b1; pc1 = 32'h50; ins1 = 32'hE28210FF;
    tick();
    check("tp_pc_a", opc1, 32'h50);
    check("tp_ready_a", ir1, 1'b1);
    pc1 = 32'h54; ins1 = 32'hE3520000;
    tick();
    check("tp_pc_b", opc1, 32'h54);
    check("tp_funct_b", fn1, 4'hA);
    iv1 = 1'b0;
    tick();
    check("tp_idle", ov1, 1'b0);

    // SKID=1 backpressure: 0x0 to output, 0x4 to skid, 0x8 refused
    ordy1 = 1'b0; iv1 = 1'b1; pc1 = 32'h0; ins1 = 32'hE28210FF;
    tick();
    check("bp_valid_0", ov1, 1'b1);
    check("bp_pc_0", opc1, 32'h0);
    check("bp_ready_0", ir1, 1'b1);
    pc1 = 32'h4; ins1 = 32'hE3A0043F;
    tick();
    check("bp_ready_full", ir1, 1'b0);
    check("bp_pc_hold1", opc1, 32'h0);
    pc1 = 32'h8; ins1 = 32'hE5943008;
    tick();
    check("bp_ready_full2", ir1, 1'b0);
    check("bp_pc_hold2", opc1, 32'h0);
    check("bp_imm_hold", imm1, 32'hFF);
    check("bp_funct_hold", fn1, 4'h4);
    check("bp_valid_hold", ov1, 1'b1);
    ordy1 = 1'b1;
    tick();
    check("drain_pc_4", opc1, 32'h4);
    check("drain_funct_4", fn1, 4'hD);
    check("drain_imm_4", imm1, 32'h3F000000);
    check("drain_ready", ir1, 1'b1);
    tick();
    check("drain_pc_8", opc1, 32'h8);
    check("drain_m2r_8", m2r1, 1'b1);
    check("drain_valid_8", ov1, 1'b1);
    iv1 = 1'b0;
    tick();
    check("drain_end", ov1, 1'b0);

    // Flush with skid full, then a flush cycle that accepts a word
    ordy1 = 1'b0; iv1 = 1'b1; pc1 = 32'h20; ins1 = 32'hE28210FF;
    tick();
    pc1 = 32'h24;
    tick();
    check("fl_full", ir1, 1'b0);
    flush = 1'b1; pc1 = 32'h28;
    tick();
    check("fl_valid", ov1, 1'b0);
    check("fl_ready", ir1, 1'b1);
    pc1 = 32'h2C;
    tick();
    check("fl_accept_drop", ov1, 1'b0);
    flush = 1'b0; ordy1 = 1'b1; pc1 = 32'h30; ins1 = 32'hE5043008;
    tick();
    check("fl_post_valid", ov1, 1'b1);
    check("fl_post_pc", opc1, 32'h30);
    check("fl_post_mw", mw1, 1'b1);
    iv1 = 1'b0;
    tick();
    check("fl_post_idle", ov1, 1'b0);

    // Reset on a stalled bundle
    ordy1 = 1'b0; iv1 = 1'b1; pc1 = 32'h40; ins1 = 32'hEBFFFFFE;
    tick();
    iv1 = 1'b0;
    check("rs_valid", ov1, 1'b1);
    check("rs_link", lk1, 1'b1);
    rst = 1'b1;
    #1;
    check("rs_in_ready1", ir1, 1'b0);
    check("rs_in_ready0", ir0, 1'b0);
    check("rs_hold_pc", opc1, 32'h40);
    tick();
    check("rs_out_valid", ov1, 1'b0);
    check("rs_out_pc", opc1, 32'h0);
    check("rs_out_imm", imm1, 32'h0);
    check("rs_out_rd", rd1, 4'd0);
    check("rs_out_link", lk1, 1'b0);
    check("rs_out_branch", br1, 1'b0);
    check("rs_out_cond", cond1, 4'h0);
    rst = 1'b0;
    tick();
    check("rs_release_ready", ir1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
